pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Sequences the 5-stage core: load-use stalls, EX-resolved redirect flushes (pc_sel from branch/JALR
//  decode), whole-pipe freeze on dmem wait, and rs1/rs2 forwarding selects for the EX operand muxes.
//  Sits beside ControlUnit. Drives every pipeline-register enable/flush and the PC enable. Keeps
//  saturating stall/flush counters and a memory-wait watchdog.
// PARAMETERS
//  RA_W          5    register-address width
//  CNT_W         16   width of perf counters (saturating)
//  MEM_WAIT_MAX  64   watchdog limit in freeze cycles; 0 disables watchdog
// PORTS
//  clk             in   1      core clock, rising edge
//  rst             in   1      asynchronous, active-high reset
//  id_rs1,id_rs2   in   RA_W   source regs of instr in ID
//  id_use_rs1/rs2  in   1      instr in ID reads rs1/rs2 (0 for LUI/JAL etc.)
//  ex_rs1,ex_rs2   in   RA_W   source regs of instr in EX
//  ex_rd           in   RA_W   dest of instr in EX
//  ex_reg_write_en in   1      EX instr writes rd
//  ex_is_load      in   1      EX instr is a load (reg_write_en && wbsel==0)
//  ex_pc_sel       in   1      redirect resolved in EX (branch taken / JALR)
//  mem_rd, wb_rd   in   RA_W   dest regs in MEM / WB
//  mem_reg_write_en,wb_reg_write_en in 1  write enables in MEM / WB
//  dmem_req        in   1      MEM stage accessing dmem this cycle
//  dmem_ready      in   1      dmem completes access this cycle
//  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out 1  register enables (1 = advance)
//  if_id_flush, id_ex_flush  out 1  load NOP into register on next edge
//  fwd_a_sel, fwd_b_sel      out 2  00 regfile, 01 MEM result, 10 WB result
//  ctrl_state      out  2      00 RUN, 01 FREEZE, 10 BUBBLE
//  stall_cycles, flush_count  out CNT_W  saturating perf counters
//  mem_timeout     out  1      sticky watchdog flag
// BEHAVIOUR
//  Reset: state RUN, counters 0, mem_timeout 0, wait counter 0. All *_en=1, flushes 0, fwd=00 (given
//   idle inputs).
//  Forwarding (combinational): fwd_a=01 if mem_reg_write_en && mem_rd!=0 && mem_rd==ex_rs1;
//   else 10 if wb match; else 00. MEM beats WB. Same rule for b/ex_rs2. x0 is never forwarded.
//  load_use = ex_is_load && ex_rd!=0 && ((id_use_rs1&&ex_rd==id_rs1)||(id_use_rs2&&ex_rd==id_rs2)).
//  freeze = dmem_req && !dmem_ready. Priority: freeze > redirect > load_use.
//  freeze: all *_en=0, flushes 0. Next state FREEZE; stays while freeze holds.
//   Redirect is held, not lost: ex_pc_sel stays valid because EX is frozen. It fires on the ready cycle.
//  redirect (ex_pc_sel, no freeze): all en=1, if_id_flush=id_ex_flush=1. flush_count += 1.
//   Overrides a same-cycle load_use; the ID instr is squashed anyway.
//  load_use (no freeze, no redirect): pc_en=if_id_en=0, id_ex_flush=1 (bubble), others en=1.
//   Next state BUBBLE for exactly one cycle, then RUN. In BUBBLE, load_use is not re-evaluated.
//   The load is now in MEM, so any later need is covered by WB forwarding.
//  stall_cycles += 1 each cycle pc_en==0. Both counters saturate at all-ones, no wrap.
//  Watchdog: the wait counter increments each FREEZE cycle and clears on leaving FREEZE.
//   On reaching MEM_WAIT_MAX (non-zero), mem_timeout sets and stays set until rst.
//   The freeze continues; the watchdog never unfreezes the pipe.
//  Async reset mid-FREEZE/BUBBLE: immediate return to reset values. No partial flush is issued.
//  Latency: all enables/flushes/forwarding are combinational, same cycle as inputs.
//   Only the state, counters and flag are registered.
// STRUCTURE
//  Shared package/header: state encodings ST_RUN/ST_FREEZE/ST_BUBBLE and FWD_RF/FWD_MEM/FWD_WB.
//  One sub-module: hazard_fwd_unit (pure combinational forwarding + load_use compare), instanced
//   once. FSM, counters and watchdog live in the top.
// TESTING
//  1 ex: add x5 in MEM, ex_rs1=5 -> fwd_a_sel=01; same rd in WB only -> 10; rd=0 -> 00.
//  2 lw x6 in EX, ID add uses rs2=6 -> pc_en=if_id_en=0, id_ex_flush=1 for 1 cycle;
//    ctrl_state 10 then 00; stall_cycles=1.
//  3 ex_pc_sel=1 with load_use also true -> both flushes=1, pc_en=1, flush_count=1, no BUBBLE.
//  4 dmem_req=1, dmem_ready=0 for 3 cycles with ex_pc_sel=1 -> all en=0 for 3 cycles.
//    Flush fires on the ready cycle; stall_cycles=3.
//  5 MEM_WAIT_MAX=4, ready held low 10 cycles -> mem_timeout rises on 4th FREEZE cycle.
//    Stays 1 after ready; cleared only by rst.
//  6 Assert rst during FREEZE -> same-cycle all en=1, state RUN, counters and flag 0.
//    Also: 2^CNT_W+5 redirects -> flush_count saturates at all-ones.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: controller states,
// forwarding selects and the bundle of pipeline-register enables/flushes.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_FREEZE = 2'b01,
    ST_BUBBLE = 2'b10
  } ctrl_state_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  // Field order matches the bit order used by the constants below.
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
  } pipe_ctrl_t;

  // Everything advances, nothing squashed.
  localparam pipe_ctrl_t CTRL_RUN    = 7'b11111_00;
  // dmem stall: hold every register, squash nothing.
  localparam pipe_ctrl_t CTRL_FREEZE = 7'b00000_00;
  // EX redirect: advance and squash the two younger instructions.
  localparam pipe_ctrl_t CTRL_FLUSH  = 7'b11111_11;
  // Load-use: hold PC and IF/ID, inject a NOP into ID/EX.
  localparam pipe_ctrl_t CTRL_BUBBLE = 7'b00111_01;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
// hazard_fwd_unit: purely combinational operand-forwarding selects for the
// EX muxes and the load-use detection compare against the ID instruction.
module hazard_fwd_unit
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] i_id_rs1,
  input  logic [RA_W-1:0] i_id_rs2,
  input  logic            i_id_use_rs1,
  input  logic            i_id_use_rs2,
  input  logic [RA_W-1:0] i_ex_rs1,
  input  logic [RA_W-1:0] i_ex_rs2,
  input  logic [RA_W-1:0] i_ex_rd,
  input  logic            i_ex_is_load,
  input  logic [RA_W-1:0] i_mem_rd,
  input  logic            i_mem_reg_write_en,
  input  logic [RA_W-1:0] i_wb_rd,
  input  logic            i_wb_reg_write_en,
  output fwd_sel_t        o_fwd_a_sel,
  output fwd_sel_t        o_fwd_b_sel,
  output logic            o_load_use
);

  // The youngest producer (MEM) wins over WB; x0 is hard-wired zero and is
  // never a forwarding source even if some instruction names it as rd.
  function automatic fwd_sel_t pick_src(
    input logic [RA_W-1:0] src,
    input logic            mem_we,
    input logic [RA_W-1:0] mem_rd,
    input logic            wb_we,
    input logic [RA_W-1:0] wb_rd
  );
    fwd_sel_t sel;
    sel = FWD_RF;
    if (mem_we && (mem_rd != '0) && (mem_rd == src)) begin
      sel = FWD_MEM;
    end else if (wb_we && (wb_rd != '0) && (wb_rd == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  logic w_hit_rs1;
  logic w_hit_rs2;

  // Forwarding selects for both EX operands.
  always_comb begin
    o_fwd_a_sel = pick_src(i_ex_rs1, i_mem_reg_write_en, i_mem_rd,
                           i_wb_reg_write_en, i_wb_rd);
    o_fwd_b_sel = pick_src(i_ex_rs2, i_mem_reg_write_en, i_mem_rd,
                           i_wb_reg_write_en, i_wb_rd);
  end

  // A load in EX whose rd is actually read by the ID instruction cannot be
  // forwarded in time; only sources the ID instruction really uses count.
  always_comb begin
    w_hit_rs1  = i_id_use_rs1 && (i_ex_rd == i_id_rs1);
    w_hit_rs2  = i_id_use_rs2 && (i_ex_rd == i_id_rs2);
    o_load_use = i_ex_is_load && (i_ex_rd != '0) && (w_hit_rs1 || w_hit_rs2);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: sequences the 5-stage core's pipeline registers.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_RUN    | normal flow; load-use is evaluated
//   ST_FREEZE | previous cycle was a dmem wait (whole pipe held)
//   ST_BUBBLE | one cycle after a load-use bubble; load-use is masked
//
// Priority each cycle: dmem freeze > EX redirect > load-use bubble.
// All enables, flushes and forwarding selects are combinational; only the
// state, the saturating perf counters and the watchdog are registered.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int RA_W         = 5,
  parameter int CNT_W        = 16,
  parameter int MEM_WAIT_MAX = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [RA_W-1:0]  i_id_rs1,
  input  logic [RA_W-1:0]  i_id_rs2,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic [RA_W-1:0]  i_ex_rs1,
  input  logic [RA_W-1:0]  i_ex_rs2,
  input  logic [RA_W-1:0]  i_ex_rd,
  input  logic             i_ex_reg_write_en,
  input  logic             i_ex_is_load,
  input  logic             i_ex_pc_sel,
  input  logic [RA_W-1:0]  i_mem_rd,
  input  logic [RA_W-1:0]  i_wb_rd,
  input  logic             i_mem_reg_write_en,
  input  logic             i_wb_reg_write_en,
  input  logic             i_dmem_req,
  input  logic             i_dmem_ready,
  output logic             o_pc_en,
  output logic             o_if_id_en,
  output logic             o_id_ex_en,
  output logic             o_ex_mem_en,
  output logic             o_mem_wb_en,
  output logic             o_if_id_flush,
  output logic             o_id_ex_flush,
  output logic [1:0]       o_fwd_a_sel,
  output logic [1:0]       o_fwd_b_sel,
  output logic [1:0]       o_ctrl_state,
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic [CNT_W-1:0] o_flush_count,
  output logic             o_mem_timeout
);

  // Wait counter is wide enough to hold MEM_WAIT_MAX itself; it parks there.
  localparam int WAIT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX + 1) : 1;
  localparam logic [WAIT_W:0]    WAIT_LIMIT = (WAIT_W + 1)'(MEM_WAIT_MAX);
  localparam logic [CNT_W-1:0]   CNT_SAT    = '1;

  ctrl_state_t       r_state;
  ctrl_state_t       w_state_next;
  pipe_ctrl_t        w_ctrl;
  fwd_sel_t          w_fwd_a;
  fwd_sel_t          w_fwd_b;
  logic              w_load_use;
  logic              w_freeze;
  logic              w_redirect;
  logic [WAIT_W-1:0] r_wait;
  logic [WAIT_W:0]   w_wait_inc;
  logic [CNT_W-1:0]  r_stall_cycles;
  logic [CNT_W-1:0]  r_flush_count;
  logic              r_mem_timeout;

  // A load that does not write rd cannot create a load-use dependency.
  hazard_fwd_unit #(
    .RA_W (RA_W)
  ) u_fwd (
    .i_id_rs1           (i_id_rs1),
    .i_id_rs2           (i_id_rs2),
    .i_id_use_rs1       (i_id_use_rs1),
    .i_id_use_rs2       (i_id_use_rs2),
    .i_ex_rs1           (i_ex_rs1),
    .i_ex_rs2           (i_ex_rs2),
    .i_ex_rd            (i_ex_rd),
    .i_ex_is_load       (i_ex_is_load && i_ex_reg_write_en),
    .i_mem_rd           (i_mem_rd),
    .i_mem_reg_write_en (i_mem_reg_write_en),
    .i_wb_rd            (i_wb_rd),
    .i_wb_reg_write_en  (i_wb_reg_write_en),
    .o_fwd_a_sel        (w_fwd_a),
    .o_fwd_b_sel        (w_fwd_b),
    .o_load_use         (w_load_use)
  );

  // While reset is asserted the pipe is released (all enables high, no
  // flushes) so nothing half-squashed is captured when reset lets go.
  always_comb begin
    w_freeze     = !i_rst && i_dmem_req && !i_dmem_ready;
    w_redirect   = !i_rst && !w_freeze && i_ex_pc_sel;
    w_ctrl       = CTRL_RUN;
    w_state_next = ST_RUN;
    if (w_freeze) begin
      // EX is held too, so a pending redirect stays valid until ready.
      w_ctrl       = CTRL_FREEZE;
      w_state_next = ST_FREEZE;
    end else if (w_redirect) begin
      // The ID instruction is squashed anyway; a load-use on it is moot.
      w_ctrl       = CTRL_FLUSH;
    end else if (!i_rst && w_load_use && (r_state != ST_BUBBLE)) begin
      // After one bubble the load sits in MEM; WB forwarding covers the rest.
      w_ctrl       = CTRL_BUBBLE;
      w_state_next = ST_BUBBLE;
    end
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Stall counter: every cycle the PC is held, saturating at all-ones.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stall_cycles <= '0;
    end else if (!w_ctrl.pc_en && (r_stall_cycles != CNT_SAT)) begin
      r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  // Flush counter: every redirect that actually fires, saturating.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_flush_count <= '0;
    end else if (w_redirect && (r_flush_count != CNT_SAT)) begin
      r_flush_count <= r_flush_count + 1'b1;
    end
  end

  assign w_wait_inc = {1'b0, r_wait} + 1'b1;

  // Watchdog: count consecutive freeze cycles, reset the count when the
  // freeze ends, and latch a sticky flag once the limit is reached. The
  // flag is report-only; it never releases the freeze.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wait        <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      if (!w_freeze) begin
        r_wait <= '0;
      end else if (w_wait_inc <= WAIT_LIMIT) begin
        r_wait <= w_wait_inc[WAIT_W-1:0];
      end
      if ((WAIT_LIMIT != '0) && w_freeze && (w_wait_inc == WAIT_LIMIT)) begin
        r_mem_timeout <= 1'b1;
      end
    end
  end

  // Output mapping.
  always_comb begin
    o_pc_en        = w_ctrl.pc_en;
    o_if_id_en     = w_ctrl.if_id_en;
    o_id_ex_en     = w_ctrl.id_ex_en;
    o_ex_mem_en    = w_ctrl.ex_mem_en;
    o_mem_wb_en    = w_ctrl.mem_wb_en;
    o_if_id_flush  = w_ctrl.if_id_flush;
    o_id_ex_flush  = w_ctrl.id_ex_flush;
    o_fwd_a_sel    = w_fwd_a;
    o_fwd_b_sel    = w_fwd_b;
    o_ctrl_state   = r_state;
    o_stall_cycles = r_stall_cycles;
    o_flush_count  = r_flush_count;
    o_mem_timeout  = r_mem_timeout;
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl. Each cycle the expected
// observation is pushed to a scoreboard when inputs are driven and popped
// and compared at the following falling edge.
module tb_pipeline_hazard_ctrl;

  localparam int RA_W  = 5;
  localparam int CNT_W = 6;
  localparam int WMAX  = 4;

  localparam logic [6:0] C_RUN = 7'b1111100;
  localparam logic [6:0] C_FRZ = 7'b0000000;
  localparam logic [6:0] C_RDR = 7'b1111111;
  localparam logic [6:0] C_LU  = 7'b0011101;
  localparam logic [1:0] S_RUN = 2'b00;
  localparam logic [1:0] S_FRZ = 2'b01;
  localparam logic [1:0] S_BUB = 2'b10;

  typedef struct packed {
    logic [6:0]       ctl;
    logic [1:0]       fa;
    logic [1:0]       fb;
    logic [1:0]       st;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] flush;
    logic             tmo;
  } obs_t;

  typedef struct packed {
    logic       ld;
    logic [4:0] ex_rd;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic       pcs;
    logic       req;
    logic       rdy;
  } stim_t;

  typedef struct packed {
    logic [4:0] mrd;
    logic       mwe;
    logic [4:0] wrd;
    logic       wwe;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [1:0] ea;
    logic [1:0] eb;
  } fwd_row_t;

  logic clk = 1'b0;
  logic rst;
  logic [RA_W-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_use_rs1, id_use_rs2, ex_reg_write_en, ex_is_load, ex_pc_sel;
  logic mem_reg_write_en, wb_reg_write_en, dmem_req, dmem_ready;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush;
  logic [1:0] fwd_a_sel, fwd_b_sel, ctrl_state;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  logic mem_timeout;

  obs_t  obs_now;
  obs_t  exp_q[$];
  string name_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .RA_W         (RA_W),
    .CNT_W        (CNT_W),
    .MEM_WAIT_MAX (WMAX)
  ) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_id_rs1           (id_rs1),
    .i_id_rs2           (id_rs2),
    .i_id_use_rs1       (id_use_rs1),
    .i_id_use_rs2       (id_use_rs2),
    .i_ex_rs1           (ex_rs1),
    .i_ex_rs2           (ex_rs2),
    .i_ex_rd            (ex_rd),
    .i_ex_reg_write_en  (ex_reg_write_en),
    .i_ex_is_load       (ex_is_load),
    .i_ex_pc_sel        (ex_pc_sel),
    .i_mem_rd           (mem_rd),
    .i_wb_rd            (wb_rd),
    .i_mem_reg_write_en (mem_reg_write_en),
    .i_wb_reg_write_en  (wb_reg_write_en),
    .i_dmem_req         (dmem_req),
    .i_dmem_ready       (dmem_ready),
    .o_pc_en            (pc_en),
    .o_if_id_en         (if_id_en),
    .o_id_ex_en         (id_ex_en),
    .o_ex_mem_en        (ex_mem_en),
    .o_mem_wb_en        (mem_wb_en),
    .o_if_id_flush      (if_id_flush),
    .o_id_ex_flush      (id_ex_flush),
    .o_fwd_a_sel        (fwd_a_sel),
    .o_fwd_b_sel        (fwd_b_sel),
    .o_ctrl_state       (ctrl_state),
    .o_stall_cycles     (stall_cycles),
    .o_flush_count      (flush_count),
    .o_mem_timeout      (mem_timeout)
  );

  assign obs_now = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush,
                    id_ex_flush, fwd_a_sel, fwd_b_sel, ctrl_state, stall_cycles,
                    flush_count, mem_timeout};

  function automatic obs_t mk(input logic [6:0] ctl, input logic [1:0] st,
                              input int stall, input int flush, input logic tmo);
    obs_t o;
    o.ctl = ctl; o.fa = 2'b00; o.fb = 2'b00; o.st = st;
    o.stall = CNT_W'(stall); o.flush = CNT_W'(flush); o.tmo = tmo;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("ctl=%b fa=%b fb=%b st=%b stall=%0d flush=%0d tmo=%b",
                     o.ctl, o.fa, o.fb, o.st, o.stall, o.flush, o.tmo);
  endfunction

  task automatic set_idle();
    id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; ex_reg_write_en = 0; ex_is_load = 0;
    ex_pc_sel = 0; mem_rd = '0; wb_rd = '0; mem_reg_write_en = 0;
    wb_reg_write_en = 0; dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic drive(input stim_t s);
    set_idle();
    ex_is_load = s.ld; ex_reg_write_en = s.ld; ex_rd = s.ex_rd;
    id_rs1 = s.rs1; id_use_rs1 = s.u1; id_rs2 = s.rs2; id_use_rs2 = s.u2;
    ex_pc_sel = s.pcs; dmem_req = s.req; dmem_ready = s.rdy;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; set_idle();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    obs_t e; string nm;
    // idle inputs, reset asserted
    exp_q.push_back(mk(C_RUN, S_RUN, 0, 0, 1'b0)); name_q.push_back("reset_idle");
    @(negedge clk);
    e = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
    if (obs_now !== e) begin
      n_err++; $display("FAIL %s: got %s, want %s", nm, fmt(obs_now), fmt(e));
    end
    // hazard inputs present while reset asserted: still released
    dmem_req = 1; ex_pc_sel = 1;
    exp_q.push_back(mk(C_RUN, S_RUN, 0, 0, 1'b0)); name_q.push_back("reset_masks_hazards");
    @(negedge clk);
    e = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
    if (obs_now !== e) begin
      n_err++; $display("FAIL %s: got %s, want %s", nm, fmt(obs_now), fmt(e));
    end
    @(posedge clk); #1;
    rst = 1'b0; set_idle();
  endtask

  task automatic test_forwarding();
    fwd_row_t rows[7];
    obs_t e; string nm;
    rows[0] = '{5'd5,  1'b1, 5'd0,  1'b0, 5'd5,  5'd0,  2'b01, 2'b00};
    rows[1] = '{5'd7,  1'b1, 5'd5,  1'b1, 5'd5,  5'd0,  2'b10, 2'b00};
    rows[2] = '{5'd0,  1'b1, 5'd0,  1'b1, 5'd0,  5'd0,  2'b00, 2'b00};
    rows[3] = '{5'd9,  1'b1, 5'd9,  1'b1, 5'd9,  5'd9,  2'b01, 2'b01};
    rows[4] = '{5'd3,  1'b0, 5'd3,  1'b1, 5'd4,  5'd3,  2'b00, 2'b10};
    rows[5] = '{5'd0,  1'b0, 5'd12, 1'b0, 5'd12, 5'd12, 2'b00, 2'b00};
    rows[6] = '{5'd17, 1'b1, 5'd17, 1'b0, 5'd1,  5'd17, 2'b00, 2'b01};
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      set_idle();
      mem_rd = rows[i].mrd; mem_reg_write_en = rows[i].mwe;
      wb_rd = rows[i].wrd; wb_reg_write_en = rows[i].wwe;
      ex_rs1 = rows[i].rs1; ex_rs2 = rows[i].rs2;
      e = mk(C_RUN, S_RUN, 0, 0, 1'b0);
      e.fa = rows[i].ea; e.fb = rows[i].eb;
      exp_q.push_back(e); name_q.push_back($sformatf("fwd_row%0d", i));
      @(negedge clk);
      e = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
      if (obs_now !== e) begin
        n_err++; $display("FAIL %s: got %s, want %s", nm, fmt(obs_now), fmt(e));
      end
    end
  endtask

  task automatic test_load_use();
    stim_t rows[5];
    logic  lu[5];
    stim_t s;
    obs_t  e; string nm;
    int    es = 0;
    rows[0] = '{1'b1, 5'd6, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0}; lu[0] = 1;
    rows[1] = '{1'b1, 5'd8, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0}; lu[1] = 1;
    rows[2] = '{1'b1, 5'd8, 5'd8, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0}; lu[2] = 0;
    rows[3] = '{1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0}; lu[3] = 0;
    rows[4] = '{1'b0, 5'd8, 5'd8, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0}; lu[4] = 0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 3; c++) begin
        @(posedge clk); #1;
        s = (c == 2) ? stim_t'('0) : rows[r];
        drive(s);
        if (c == 0) e = mk(lu[r] ? C_LU : C_RUN, S_RUN, es, 0, 1'b0);
        else if (c == 1) e = mk(C_RUN, lu[r] ? S_BUB : S_RUN, es, 0, 1'b0);
        else e = mk(C_RUN, S_RUN, es, 0, 1'b0);
        exp_q.push_back(e); name_q.push_back($sformatf("lu_row%0d_c%0d", r, c));
        if (c == 0 && lu[r]) es++;
        @(negedge clk);
        e = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
        if (obs_now !== e) begin
          n_err++; $display("FAIL %s: got %s, want %s", nm, fmt(obs_now), fmt(e));
        end
      end
    end
  endtask

  task automatic test_redirect();
    stim_t s[4];
    obs_t  ex[4];
    obs_t  e; string nm;
    do_reset();
    s[0] = '{1'b1, 5'd6, 5'd6, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    s[1] = '{1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    s[2] = s[1];
    s[3] = '0;
    ex[0] = mk(C_RDR, S_RUN, 0, 0, 1'b0);
    ex[1] = mk(C_RDR, S_RUN, 0, 1, 1'b0);
    ex[2] = mk(C_RDR, S_RUN, 0, 2, 1'b0);
    ex[3] = mk(C_RUN, S_RUN, 0, 3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      drive(s[i]);
      exp_q.push_back(ex[i]); name_q.push_back($sformatf("redirect_c%0d", i));
      @(negedge clk);
      e = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
      if (obs_now !== e) begin
        n_err++; $display("FAIL %s: got %s, want %s", nm, fmt(obs_now), fmt(e));
      end
    end
  endtask

  task automatic test_freeze_redirect();
    stim_t s[13];
    obs_t  ex[13];
    obs_t  e; string nm;
    stim_t frz_all, rdy_all, frz, lus;
    do_reset();
    frz_all = '{1'b1, 5'd6, 5'd6, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0};
    rdy_all = '{1'b1, 5'd6, 5'd6, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1};
    frz     = '{1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    lus     = '{1'b1, 5'd6, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    s[0] = frz_all; ex[0] = mk(C_FRZ, S_RUN, 0, 0, 1'b0);
    s[1] = frz_all; ex[1] = mk(C_FRZ, S_FRZ, 1, 0, 1'b0);
    s[2] = frz_all; ex[2] = mk(C_FRZ, S_FRZ, 2, 0, 1'b0);
    s[3] = rdy_all; ex[3] = mk(C_RDR, S_FRZ, 3, 0, 1'b0);
    s[4] = '0;      ex[4] = mk(C_RUN, S_RUN, 3, 1, 1'b0);
    s[5] = frz;     ex[5] = mk(C_FRZ, S_RUN, 3, 1, 1'b0);
    s[6] = frz;     ex[6] = mk(C_FRZ, S_FRZ, 4, 1, 1'b0);
    s[7] = frz;     ex[7] = mk(C_FRZ, S_FRZ, 5, 1, 1'b0);
    s[8] = '0;      ex[8] = mk(C_RUN, S_FRZ, 6, 1, 1'b0);
    s[9] = frz;     ex[9] = mk(C_FRZ, S_RUN, 6, 1, 1'b0);
    s[10] = lus;    ex[10] = mk(C_LU, S_FRZ, 7, 1, 1'b0);
    s[11] = '0;     ex[11] = mk(C_RUN, S_BUB, 8, 1, 1'b0);
    s[12] = '0;     ex[12] = mk(C_RUN, S_RUN, 8, 1, 1'b0);
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      drive(s[i]);
      exp_q.push_back(ex[i]); name_q.push_back($sformatf("freeze_c%0d", i));
      @(negedge clk);
      e = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
      if (obs_now !== e) begin
        n_err++; $display("FAIL %s: got %s, want %s", nm, fmt(obs_now), fmt(e));
      end
    end
  endtask

  task automatic test_watchdog();
    obs_t e; string nm;
    stim_t s;
    do_reset();
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk); #1;
      s = '0;
      if (k <= 11) s.req = 1'b1;
      if (k == 11) s.rdy = 1'b1;
      drive(s);
      if (k <= 10) e = mk(C_FRZ, (k == 1) ? S_RUN : S_FRZ, k - 1, 0, k >= WMAX + 1);
      else if (k == 11) e = mk(C_RUN, S_FRZ, 10, 0, 1'b1);
      else e = mk(C_RUN, S_RUN, 10, 0, 1'b1);
      exp_q.push_back(e); name_q.push_back($sformatf("watchdog_k%0d", k));
      @(negedge clk);
      e = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
      if (obs_now !== e) begin
        n_err++; $display("FAIL %s: got %s, want %s", nm, fmt(obs_now), fmt(e));
      end
    end
  endtask

  // Continues from the watchdog state (stall=10, timeout set).
  task automatic test_async_reset();
    stim_t s[8];
    obs_t  ex[8];
    logic  rst_mid[8];
    obs_t  e; string nm;
    stim_t frz, lus;
    frz = '{1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    lus = '{1'b1, 5'd6, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    s[0] = frz; rst_mid[0] = 0; ex[0] = mk(C_FRZ, S_RUN, 10, 0, 1'b1);
    s[1] = frz; rst_mid[1] = 0; ex[1] = mk(C_FRZ, S_FRZ, 11, 0, 1'b1);
    s[2] = frz; rst_mid[2] = 1; ex[2] = mk(C_RUN, S_RUN, 0, 0, 1'b0);
    s[3] = frz; rst_mid[3] = 0; ex[3] = mk(C_FRZ, S_RUN, 0, 0, 1'b0);
    s[4] = '0;  rst_mid[4] = 0; ex[4] = mk(C_RUN, S_FRZ, 1, 0, 1'b0);
    s[5] = lus; rst_mid[5] = 0; ex[5] = mk(C_LU,  S_RUN, 1, 0, 1'b0);
    s[6] = lus; rst_mid[6] = 1; ex[6] = mk(C_RUN, S_RUN, 0, 0, 1'b0);
    s[7] = '0;  rst_mid[7] = 0; ex[7] = mk(C_RUN, S_RUN, 0, 0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      rst = 1'b0;
      drive(s[i]);
      if (rst_mid[i]) begin
        #1 rst = 1'b1;
      end
      exp_q.push_back(ex[i]); name_q.push_back($sformatf("async_rst_c%0d", i));
      @(negedge clk);
      e = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
      if (obs_now !== e) begin
        n_err++; $display("FAIL %s: got %s, want %s", nm, fmt(obs_now), fmt(e));
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_saturation();
    obs_t e; string nm;
    stim_t s;
    int n = (1 << CNT_W) + 5;
    int sat = (1 << CNT_W) - 1;
    do_reset();
    for (int i = 0; i <= n; i++) begin
      @(posedge clk); #1;
      s = '0;
      s.pcs = (i < n);
      drive(s);
      e = mk((i < n) ? C_RDR : C_RUN, S_RUN, 0, (i < sat) ? i : sat, 1'b0);
      exp_q.push_back(e); name_q.push_back($sformatf("sat_flush_%0d", i));
      @(negedge clk);
      e = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
      if (obs_now !== e) begin
        n_err++; $display("FAIL %s: got %s, want %s", nm, fmt(obs_now), fmt(e));
      end
    end
    for (int j = 0; j <= n; j++) begin
      @(posedge clk); #1;
      s = '0;
      s.req = 1'b1;
      s.rdy = (j == n);
      drive(s);
      e = mk((j < n) ? C_FRZ : C_RUN, (j == 0) ? S_RUN : S_FRZ,
             (j < sat) ? j : sat, sat, j >= WMAX);
      exp_q.push_back(e); name_q.push_back($sformatf("sat_stall_%0d", j));
      @(negedge clk);
      e = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
      if (obs_now !== e) begin
        n_err++; $display("FAIL %s: got %s, want %s", nm, fmt(obs_now), fmt(e));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    test_reset();
    test_forwarding();
    test_load_use();
    test_redirect();
    test_freeze_redirect();
    test_watchdog();
    test_async_reset();
    test_saturation();
    if (exp_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
